wb_pro_unit: RTL
================

Name: wb_pro_unit

Overview:
Writeback stage of the pro (secondary) pipe. It sits directly downstream of the MEM/WB pro pipeline register and drives the pro register-file write port.
- Loads: waits for data-cache read data, then aligns, sign/zero-extends and merges it (LB/LH/LW/LWL/LWR).
- Non-loads: forwards the ALU result.
- Raises a stall to the hazard unit while a load is outstanding.
- Latches its own load context, so correctness does not depend on upstream registers holding.

Parameters:
WAIT_LIMIT, 255, max cycles spent in WAIT before a load is abandoned with wb_err; 0 disables the timeout.

Ports:
clk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
in_wRegEn  in  1  instruction writes a GPR
in_wRegAddr  in  5  destination GPR
in_aluAns  in  32  ALU result / effective address
in_pc  in  32  instruction PC
in_reverse  in  1  pro instruction is older than the main-pipe instruction in the same WB cycle
in_rwmem  in  1  1 = load awaiting cache data
in_rsize  in  3  1 = byte, 2 = half, 4 = word; any other value is treated as word
in_signExt  in  1  sign-extend byte/half
in_left_right  in  2  00 normal, 01 LWL, 10 LWR, 11 treated as 00
in_rtReg  in  32  old rt value, for LWL/LWR merge
dc_rvalid  in  1  data-cache read data valid
dc_rdata  in  32  data-cache read word
rf_we  out  1  register-file write enable
rf_waddr  out  5  register-file write address
rf_wdata  out  32  register-file write data
wb_stall  out  1  freeze all stages upstream of WB
wb_err  out  1  one-cycle pulse: load timed out
commit_pc  out  32  PC of the instruction written this cycle
commit_reverse  out  1  registered in_reverse, for trace ordering

Behaviour:
- States: IDLE, WAIT.
- Reset: state IDLE; rf_we=0, rf_waddr=0, rf_wdata=0, wb_err=0, commit_pc=0, commit_reverse=0; wait counter=0; captured context cleared.
- IDLE with in_rwmem=0:
  - next edge: rf_we<=in_wRegEn & (in_wRegAddr!=0), rf_waddr<=in_wRegAddr, rf_wdata<=in_aluAns, commit_pc<=in_pc, commit_reverse<=in_reverse.
  - Latency 1 cycle.
- IDLE with in_rwmem=1 and dc_rvalid=1: aligned data is written at the next edge. Latency 1; no stall.
- IDLE with in_rwmem=1 and dc_rvalid=0:
  - wb_stall=1 combinationally in the same cycle.
  - All in_* fields are captured; next state WAIT; counter cleared.
  - rf_we<=0 at that edge.
- WAIT:
  - All in_* inputs are ignored; the captured context is used.
  - wb_stall = ~dc_rvalid.
  - On dc_rvalid: write aligned data from the captured context at the next edge; return to IDLE.
  - Otherwise the counter increments.
  - If WAIT_LIMIT!=0 and the counter reaches WAIT_LIMIT-1 without dc_rvalid: the next edge sets wb_err<=1 and rf_we<=0, and the state returns to IDLE. wb_stall drops in that cycle.
- rf_we is a single-cycle pulse per committed instruction; it is 0 in every cycle where nothing commits.
- Alignment (a = captured in_aluAns[1:0], m = dc_rdata, rt = in_rtReg):
  - Byte: lane a, i.e. m[8a+7:8a]. Half: lane a[1], i.e. m[16a[1]+15:16a[1]]. Extended by in_signExt.
  - Word: m.
  - LWL: a=0 {m[7:0],rt[23:0]}; a=1 {m[15:0],rt[15:0]}; a=2 {m[23:0],rt[7:0]}; a=3 m.
  - LWR: a=0 m; a=1 {rt[31:24],m[31:8]}; a=2 {rt[31:16],m[31:16]}; a=3 {rt[31:8],m[31:24]}.
  - in_left_right!=00 overrides in_rsize.
- Misaligned half/word addresses are not checked; the exception was raised in MEM.
- Reset mid-WAIT: abandons the load with no write. The data cache shares aresetn, so no stale dc_rvalid can follow.
- dc_rvalid while IDLE with in_rwmem=0 is ignored.

Optional Feature:
WB_PRO_FWD_EN:
- Defined: adds outputs fwd_valid (1) and fwd_data (32), combinational from the same-cycle aligned result. fwd_valid = result available this cycle (IDLE load with dc_rvalid, WAIT with dc_rvalid, or non-load with in_wRegEn). Allows EX bypass one cycle earlier.
- Undefined: the ports are absent; forwarding uses rf_* only.

Decomposition:
- Package wb_pro_pkg holds:
  - state enum;
  - rsize constants SZ_BYTE=1, SZ_HALF=2, SZ_WORD=4;
  - LR_NONE=0, LR_LWL=1, LR_LWR=2;
  - a load-context struct (wRegEn, wRegAddr, aluAns, pc, reverse, rsize, signExt, left_right, rtReg).
- One sub-module: load_align, purely combinational: (m, rt, addr, rsize, signExt, left_right) -> 32-bit data.

Test Plan:
- ALU op: in_wRegEn=1, addr 5, aluAns=0x1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, wb_stall never 1.
- LB hit: aluAns[1:0]=3, signExt=1, dc_rdata=0x80FF_0000 same cycle -> rf_wdata=0xFFFF_FF80.
- LWL miss: a=1, rt=0xAABBCCDD, dc_rvalid 4 cycles late with 0x11223344 -> stall for exactly 4 cycles; then rf_wdata=0x3344CCDD. Inputs changed during WAIT must not affect the result.
- LWR: a=2, rt=0xAABBCCDD, m=0x11223344 -> 0xAABB1122; LHU a=2, m=0xFFEE0000 -> 0x0000FFEE.
- Timeout: WAIT_LIMIT=8, no dc_rvalid -> wb_err pulses once after 8 WAIT cycles, rf_we stays 0, state IDLE.
- Reset asserted mid-WAIT -> all outputs 0 at the next edge, no write. rf_waddr=0 with wRegEn=1 -> rf_we=0.

Source files
------------

// File: rtl/wb_pro_pkg.sv
// Shared types and encodings for the pro-pipe writeback stage (wb_pro_unit).
package wb_pro_pkg;

  typedef enum logic [0:0] {StIdle, StWait} wb_state_e;

  localparam logic [2:0] SZ_BYTE = 3'd1;
  localparam logic [2:0] SZ_HALF = 3'd2;
  localparam logic [2:0] SZ_WORD = 3'd4;

  localparam logic [1:0] LR_NONE = 2'd0;
  localparam logic [1:0] LR_LWL  = 2'd1;
  localparam logic [1:0] LR_LWR  = 2'd2;

  typedef struct packed {
    logic        wRegEn;
    logic [4:0]  wRegAddr;
    logic [31:0] aluAns;
    logic [31:0] pc;
    logic        reverse;
    logic [2:0]  rsize;
    logic        signExt;
    logic [1:0]  left_right;
    logic [31:0] rtReg;
  } load_ctx_t;

endpackage

// File: rtl/wb_pro_unit_if.sv
// Bundle of MEM/WB, data-cache and register-file signals around wb_pro_unit.
// Optional forwarding outputs appear when WB_PRO_FWD_EN is defined.
interface wb_pro_unit_if;
  logic        in_wRegEn;
  logic [4:0]  in_wRegAddr;
  logic [31:0] in_aluAns;
  logic [31:0] in_pc;
  logic        in_reverse;
  logic        in_rwmem;
  logic [2:0]  in_rsize;
  logic        in_signExt;
  logic [1:0]  in_left_right;
  logic [31:0] in_rtReg;
  logic        dc_rvalid;
  logic [31:0] dc_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_stall;
  logic        wb_err;
  logic [31:0] commit_pc;
  logic        commit_reverse;
`ifdef WB_PRO_FWD_EN
  logic        fwd_valid;
  logic [31:0] fwd_data;

  modport master (
    output in_wRegEn, in_wRegAddr, in_aluAns, in_pc, in_reverse, in_rwmem, in_rsize,
           in_signExt, in_left_right, in_rtReg, dc_rvalid, dc_rdata,
    input  rf_we, rf_waddr, rf_wdata, wb_stall, wb_err, commit_pc, commit_reverse,
           fwd_valid, fwd_data
  );
  modport slave (
    input  in_wRegEn, in_wRegAddr, in_aluAns, in_pc, in_reverse, in_rwmem, in_rsize,
           in_signExt, in_left_right, in_rtReg, dc_rvalid, dc_rdata,
    output rf_we, rf_waddr, rf_wdata, wb_stall, wb_err, commit_pc, commit_reverse,
           fwd_valid, fwd_data
  );
`else
  modport master (
    output in_wRegEn, in_wRegAddr, in_aluAns, in_pc, in_reverse, in_rwmem, in_rsize,
           in_signExt, in_left_right, in_rtReg, dc_rvalid, dc_rdata,
    input  rf_we, rf_waddr, rf_wdata, wb_stall, wb_err, commit_pc, commit_reverse
  );
  modport slave (
    input  in_wRegEn, in_wRegAddr, in_aluAns, in_pc, in_reverse, in_rwmem, in_rsize,
           in_signExt, in_left_right, in_rtReg, dc_rvalid, dc_rdata,
    output rf_we, rf_waddr, rf_wdata, wb_stall, wb_err, commit_pc, commit_reverse
  );
`endif
endinterface

// File: rtl/load_align.sv
// Combinational load data aligner: lane select, sign/zero extension and LWL/LWR merge.
module load_align
  import wb_pro_pkg::*;
(
  input  logic [31:0] m_i,
  input  logic [31:0] rt_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  rsize_i,
  input  logic        sign_ext_i,
  input  logic [1:0]  left_right_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = m_i[{addr_i, 3'b000} +: 8];
    half_v = m_i[{addr_i[1], 4'b0000} +: 16];
    data_o = m_i;
    // Unaligned-left/right forms take precedence over the access size.
    case (left_right_i)
      LR_LWL: begin
        case (addr_i)
          2'd0:    data_o = {m_i[7:0], rt_i[23:0]};
          2'd1:    data_o = {m_i[15:0], rt_i[15:0]};
          2'd2:    data_o = {m_i[23:0], rt_i[7:0]};
          default: data_o = m_i;
        endcase
      end
      LR_LWR: begin
        case (addr_i)
          2'd0:    data_o = m_i;
          2'd1:    data_o = {rt_i[31:24], m_i[31:8]};
          2'd2:    data_o = {rt_i[31:16], m_i[31:16]};
          default: data_o = {rt_i[31:8], m_i[31:24]};
        endcase
      end
      default: begin
        case (rsize_i)
          SZ_BYTE: data_o = {{24{sign_ext_i & byte_v[7]}}, byte_v};
          SZ_HALF: data_o = {{16{sign_ext_i & half_v[15]}}, half_v};
          default: data_o = m_i;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/wb_pro_unit.sv
// Pro-pipe writeback: commits ALU results or aligned load data, stalling while a load waits.
// Define WB_PRO_FWD_EN to expose same-cycle forwarding outputs on the interface.
module wb_pro_unit
  import wb_pro_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input logic          clk,
  input logic          aresetn,
  wb_pro_unit_if.slave bus
);

  localparam int unsigned CntW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

  wb_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  load_ctx_t       ctx_q;
  load_ctx_t       live_ctx;
  load_ctx_t       cur_ctx;
  logic [31:0]     align_data;
  logic            commit_alu;
  logic            commit_load;
  logic            timeout_hit;

  logic            rf_we_q;
  logic [4:0]      rf_waddr_q;
  logic [31:0]     rf_wdata_q;
  logic            wb_err_q;
  logic [31:0]     commit_pc_q;
  logic            commit_reverse_q;

  always_comb begin
    live_ctx = '{wRegEn:     bus.in_wRegEn,
                 wRegAddr:   bus.in_wRegAddr,
                 aluAns:     bus.in_aluAns,
                 pc:         bus.in_pc,
                 reverse:    bus.in_reverse,
                 rsize:      bus.in_rsize,
                 signExt:    bus.in_signExt,
                 left_right: bus.in_left_right,
                 rtReg:      bus.in_rtReg};
    // While waiting, upstream may have moved on; only the captured context is trusted.
    cur_ctx     = (state_q == StWait) ? ctx_q : live_ctx;
    commit_alu  = (state_q == StIdle) && !bus.in_rwmem;
    commit_load = bus.dc_rvalid && ((state_q == StWait) || bus.in_rwmem);
    timeout_hit = (WAIT_LIMIT != 0) && (state_q == StWait) && !bus.dc_rvalid &&
                  (cnt_q == CntW'(WAIT_LIMIT - 1));
  end

  load_align u_load_align (
    .m_i         (bus.dc_rdata),
    .rt_i        (cur_ctx.rtReg),
    .addr_i      (cur_ctx.aluAns[1:0]),
    .rsize_i     (cur_ctx.rsize),
    .sign_ext_i  (cur_ctx.signExt),
    .left_right_i(cur_ctx.left_right),
    .data_o      (align_data)
  );

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      ctx_q            <= '0;
      rf_we_q          <= 1'b0;
      rf_waddr_q       <= '0;
      rf_wdata_q       <= '0;
      wb_err_q         <= 1'b0;
      commit_pc_q      <= '0;
      commit_reverse_q <= 1'b0;
    end else begin
      rf_we_q  <= 1'b0;
      wb_err_q <= 1'b0;
      if (commit_alu || commit_load) begin
        rf_we_q          <= cur_ctx.wRegEn && (cur_ctx.wRegAddr != '0);
        rf_waddr_q       <= cur_ctx.wRegAddr;
        rf_wdata_q       <= commit_load ? align_data : cur_ctx.aluAns;
        commit_pc_q      <= cur_ctx.pc;
        commit_reverse_q <= cur_ctx.reverse;
      end
      unique case (state_q)
        StIdle: begin
          if (bus.in_rwmem && !bus.dc_rvalid) begin
            state_q <= StWait;
            ctx_q   <= live_ctx;
            cnt_q   <= '0;
          end
        end
        StWait: begin
          if (bus.dc_rvalid) begin
            state_q <= StIdle;
          end else if (timeout_hit) begin
            state_q  <= StIdle;
            wb_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.wb_stall       = !bus.dc_rvalid &&
                              ((state_q == StWait) ? !timeout_hit : bus.in_rwmem);
  assign bus.rf_we          = rf_we_q;
  assign bus.rf_waddr       = rf_waddr_q;
  assign bus.rf_wdata       = rf_wdata_q;
  assign bus.wb_err         = wb_err_q;
  assign bus.commit_pc      = commit_pc_q;
  assign bus.commit_reverse = commit_reverse_q;

`ifdef WB_PRO_FWD_EN
  assign bus.fwd_valid = commit_load || (commit_alu && bus.in_wRegEn);
  assign bus.fwd_data  = commit_load ? align_data : bus.in_aluAns;
`endif

endmodule
